// File: rtl/fft_result_reader_pkg.sv
// Shared types, default sizes and the address bit-reversal helper for the
// FFT result reader.
package fft_result_reader_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FFT_POINTS = 64;
  localparam int DEF_ADDR_WIDTH = 6;

  // Widest address the bitrev helper handles.
  localparam int BITREV_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int unsigned w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX; i++) begin
      if (i < w) begin
        r = r | (((v >> i) & BITREV_MAX'(1)) << (w - 1 - i));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry buffer whose head entry drives registered outputs directly, so
// data and valid are flop outputs and hold while the consumer stalls.
module fft_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  logic             head_v_q, head_v_d;
  logic             tail_v_q, tail_v_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign pop = head_v_q & out_ready_i;

  // Pop first, then place the pushed beat into whichever slot is free, so a
  // simultaneous pop and push on a single-entry buffer keeps one beat.
  always_comb begin
    head_v_d = head_v_q;
    tail_v_d = tail_v_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (pop) begin
      if (tail_v_q) begin
        head_d   = tail_q;
        head_v_d = 1'b1;
        tail_v_d = 1'b0;
      end else begin
        head_v_d = 1'b0;
      end
    end
    if (push_i) begin
      if (!head_v_d) begin
        head_d   = push_data_i;
        head_v_d = 1'b1;
      end else begin
        tail_d   = push_data_i;
        tail_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      head_v_q <= head_v_d;
      tail_v_q <= tail_v_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  assign out_valid_o = head_v_q;
  assign out_data_o  = head_q;
  assign count_o     = {head_v_q & tail_v_q, head_v_q ^ tail_v_q};

endmodule

// File: rtl/fft_result_reader.sv
// Drains one frame of FFT results from the controller's read port after each
// done pulse and streams them out as valid/ready beats tagged with their bin.
module fft_result_reader
  import fft_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FFT_POINTS  = DEF_FFT_POINTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int BIT_REVERSE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_in_real,
  input  logic [DATA_WIDTH-1:0] data_in_imag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_imag,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  done_dropped,
  output rd_state_t             dbg_state
);

  localparam int PW = 2 * DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(FFT_POINTS - 1);
  localparam bit USE_REV = (BIT_REVERSE != 0);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic                  infl_q, infl_d;
  logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
  logic                  infl_last_q, infl_last_d;
  logic                  frame_done_q, frame_done_d;
  logic                  done_dropped_q, done_dropped_d;

  logic                  fifo_valid;
  logic [PW-1:0]         fifo_out;
  logic [1:0]            fifo_count;
  logic [1:0]            occ_after_pop;
  logic                  beat_pop;
  logic                  last_hs;

  // A beat moves on a cycle where m_valid and m_ready are both high; m_valid
  // never drops and the payload never changes until that cycle arrives.
  assign beat_pop = fifo_valid & m_ready;
  assign last_hs  = beat_pop & m_last;

  // Credit check counts the slot freed by this cycle's pop, which keeps the
  // pipeline at one beat per cycle while never exceeding two beats in flight.
  assign occ_after_pop = fifo_count - {1'b0, beat_pop};
  assign rd_en = (state_q == ST_READ) && ((occ_after_pop + {1'b0, infl_q}) < 2'd2);

  assign addr_out = USE_REV ? ADDR_WIDTH'(bitrev(BITREV_MAX'(k_q), ADDR_WIDTH)) : k_q;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    infl_d         = rd_en;
    infl_idx_d     = addr_out;
    infl_last_d    = rd_en && (k_q == K_LAST);
    frame_done_d   = last_hs;
    done_dropped_d = done_dropped_q | (done && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d = ST_READ;
          k_d     = '0;
        end
      end
      ST_READ: begin
        if (rd_en) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_FLUSH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      infl_q         <= 1'b0;
      infl_idx_q     <= '0;
      infl_last_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      done_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      infl_q         <= infl_d;
      infl_idx_q     <= infl_idx_d;
      infl_last_q    <= infl_last_d;
      frame_done_q   <= frame_done_d;
      done_dropped_q <= done_dropped_d;
    end
  end

  fft_skid_fifo #(
    .WIDTH(PW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (infl_q),
    .push_data_i({data_in_real, data_in_imag, infl_idx_q, infl_last_q}),
    .out_valid_o(fifo_valid),
    .out_data_o (fifo_out),
    .out_ready_i(m_ready),
    .count_o    (fifo_count)
  );

  assign m_valid = fifo_valid;
  assign {m_real, m_imag, m_index, m_last} = fifo_out;

  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign done_dropped = done_dropped_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: natural-order and bit-reversed instances run
// side by side against a controller model and a frame-level reference.
module tb_fft_result_reader;
  import fft_result_reader_pkg::*;

  localparam int DW = 16;
  localparam int NP = 64;
  localparam int AW = 6;
  localparam int PW = 2 * DW + AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic m_ready;
  int   cyc = 0;
  int   rmode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals (index 0 natural, 1 bit-reversed) -------
  logic          rd_en        [2];
  logic [AW-1:0] addr_out     [2];
  logic [DW-1:0] din_re       [2];
  logic [DW-1:0] din_im       [2];
  logic          m_valid      [2];
  logic [DW-1:0] m_real       [2];
  logic [DW-1:0] m_imag       [2];
  logic [AW-1:0] m_index      [2];
  logic          m_last       [2];
  logic          busy         [2];
  logic          frame_done   [2];
  logic          done_dropped [2];
  rd_state_t     dbg_state    [2];

  fft_result_reader #(.DATA_WIDTH(DW), .FFT_POINTS(NP), .ADDR_WIDTH(AW), .BIT_REVERSE(0)) u_dut_nat (
    .clk(clk), .rst(rst), .done(done), .rd_en(rd_en[0]), .addr_out(addr_out[0]),
    .data_in_real(din_re[0]), .data_in_imag(din_im[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_real(m_real[0]), .m_imag(m_imag[0]), .m_index(m_index[0]), .m_last(m_last[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .done_dropped(done_dropped[0]), .dbg_state(dbg_state[0])
  );

  fft_result_reader #(.DATA_WIDTH(DW), .FFT_POINTS(NP), .ADDR_WIDTH(AW), .BIT_REVERSE(1)) u_dut_rev (
    .clk(clk), .rst(rst), .done(done), .rd_en(rd_en[1]), .addr_out(addr_out[1]),
    .data_in_real(din_re[1]), .data_in_imag(din_im[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_real(m_real[1]), .m_imag(m_imag[1]), .m_index(m_index[1]), .m_last(m_last[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .done_dropped(done_dropped[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- controller model: one-cycle read latency -------------
  logic [DW-1:0] mem_re [NP];
  logic [DW-1:0] mem_im [NP];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        din_re[i] <= mem_re[addr_out[i]];
        din_im[i] <= mem_im[addr_out[i]];
      end else begin
        din_re[i] <= DW'($urandom);
        din_im[i] <= DW'($urandom);
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [PW-1:0] exp_q      [2][$];
  logic [AW-1:0] exp_addr_q [2][$];
  logic [PW-1:0] got_q      [2][$];
  int            got_st_q   [2][$];
  logic [AW-1:0] rd_addr_q  [2][$];
  int            fd_st_q    [2][$];
  int            rd_first [2], valid_first [2];
  int            busy_cycles [2], valid_cycles [2], max_out [2], stall_viol [2];
  logic          stall_prev [2];
  logic [PW-1:0] prev_pay [2];
  int            checks = 0;
  int            errors = 0;

  always @(negedge clk) begin : monitor
    logic [PW-1:0] pay;
    for (int i = 0; i < 2; i++) begin
      pay = {m_real[i], m_imag[i], m_index[i], m_last[i]};
      if (rd_en[i]) begin
        if (rd_addr_q[i].size() == 0) rd_first[i] = cyc;
        rd_addr_q[i].push_back(addr_out[i]);
      end
      if (m_valid[i]) begin
        if (valid_cycles[i] == 0) valid_first[i] = cyc;
        valid_cycles[i]++;
      end
      if (m_valid[i] && m_ready) begin
        got_q[i].push_back(pay);
        got_st_q[i].push_back(cyc);
      end
      if (busy[i]) busy_cycles[i]++;
      if (frame_done[i]) fd_st_q[i].push_back(cyc);
      if (stall_prev[i] && (!m_valid[i] || pay != prev_pay[i])) stall_viol[i]++;
      stall_prev[i] = m_valid[i] && !m_ready;
      prev_pay[i]   = pay;
      if (rd_addr_q[i].size() - got_q[i].size() > max_out[i])
        max_out[i] = rd_addr_q[i].size() - got_q[i].size();
    end
  end

  task automatic mon_clear();
    for (int i = 0; i < 2; i++) begin
      got_q[i].delete(); got_st_q[i].delete(); rd_addr_q[i].delete(); fd_st_q[i].delete();
      rd_first[i] = -1; valid_first[i] = -1;
      busy_cycles[i] = 0; valid_cycles[i] = 0; max_out[i] = 0; stall_viol[i] = 0;
      stall_prev[i] = 1'b0; prev_pay[i] = '0;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_rev(int j);
    int r = 0;
    int v = j;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < NP; a++) begin
      mem_re[a] = rnd ? DW'($urandom) : DW'(a);
      mem_im[a] = rnd ? DW'($urandom) : ~DW'(a);
    end
  endtask

  task automatic build_exp();
    int idx;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      exp_addr_q[i].delete();
      for (int j = 0; j < NP; j++) begin
        idx = (i == 1) ? ref_rev(j) : j;
        exp_addr_q[i].push_back(AW'(idx));
        exp_q[i].push_back({mem_re[idx], mem_im[idx], AW'(idx), (j == NP - 1)});
      end
    end
  endtask

  function automatic int first_bad(int i);
    for (int j = 0; j < NP; j++) begin
      if (j >= got_q[i].size()) return j;
      if (got_q[i][j] !== exp_q[i][j]) return j;
    end
    if (got_q[i].size() != NP) return NP;
    return -1;
  endfunction

  function automatic logic [PW-1:0] got_at(int i, int j);
    return (j >= 0 && j < got_q[i].size()) ? got_q[i][j] : '0;
  endfunction

  function automatic logic [PW-1:0] exp_at(int i, int j);
    return (j >= 0 && j < NP) ? exp_q[i][j] : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_done(output int n_edge);
    @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    n_edge = cyc;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    int n = 0;
    while ((fd_st_q[0].size() == 0 || fd_st_q[1].size() == 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = (n < budget);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int cnt, input int budget, output bit ok);
    int n = 0;
    while (got_q[0].size() < cnt && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = (n < budget);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rd_en[i], addr_out[i], m_valid[i], m_real[i], m_imag[i], m_index[i], m_last[i],
           busy[i], frame_done[i], done_dropped[i]} !== '0 || dbg_state[i] !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: rd_en=%b addr=%0d valid=%b busy=%b state=%0d, expected all zero / IDLE",
                 i, rd_en[i], addr_out[i], m_valid[i], busy[i], dbg_state[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mon_clear();
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_addr_q[i].size() != 0 || valid_cycles[i] != 0) begin
        errors++;
        $display("FAIL reset_idle inst%0d: reads=%0d valid_cycles=%0d, expected 0 and 0",
                 i, rd_addr_q[i].size(), valid_cycles[i]);
      end
    end
  endtask

  task automatic test_full_rate();
    int n;
    bit ok;
    int bad, last_st;
    fill_mem(1'b0);
    build_exp();
    rmode = 0;
    mon_clear();
    pulse_done(n);
    wait_frame(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_rate_timeout: no frame_done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = first_bad(i);
      checks++;
      if (bad != -1) begin
        errors++;
        $display("FAIL full_rate_frame inst%0d: beat %0d got %h (of %0d beats), expected %h (of %0d)",
                 i, bad, got_at(i, bad), got_q[i].size(), exp_at(i, bad), NP);
      end
      checks++;
      if (rd_first[i] != n || valid_first[i] != n + 2) begin
        errors++;
        $display("FAIL full_rate_latency inst%0d: first rd_en cycle %0d, first m_valid cycle %0d, expected %0d and %0d",
                 i, rd_first[i], valid_first[i], n, n + 2);
      end
      // Beat j is accepted in the cycle that starts at edge n+2+j.
      last_st = (got_st_q[i].size() == NP) ? got_st_q[i][NP-1] : -1;
      checks++;
      if (last_st != n + NP + 1 || valid_cycles[i] != NP) begin
        errors++;
        $display("FAIL full_rate_throughput inst%0d: last beat cycle %0d, valid cycles %0d, expected %0d and %0d",
                 i, last_st, valid_cycles[i], n + NP + 1, NP);
      end
      checks++;
      if (fd_st_q[i].size() != 1 || fd_st_q[i][0] != n + NP + 2) begin
        errors++;
        $display("FAIL full_rate_frame_done inst%0d: %0d pulses, first at cycle %0d, expected 1 pulse at %0d",
                 i, fd_st_q[i].size(), (fd_st_q[i].size() > 0) ? fd_st_q[i][0] : -1, n + NP + 2);
      end
      checks++;
      if (busy_cycles[i] != NP + 2 || done_dropped[i] !== 1'b0) begin
        errors++;
        $display("FAIL full_rate_busy inst%0d: busy cycles %0d, done_dropped %b, expected %0d and 0",
                 i, busy_cycles[i], done_dropped[i], NP + 2);
      end
    end
  endtask

  task automatic test_bit_reverse();
    int n;
    bit ok;
    int bad, idx_err, last_cnt, last_pos;
    logic [PW-1:0] pay;
    fill_mem(1'b0);
    build_exp();
    rmode = 0;
    mon_clear();
    pulse_done(n);
    wait_frame(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bitrev_timeout: no frame_done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = -1;
      for (int j = 0; j < NP; j++) begin
        if (j >= rd_addr_q[i].size() || rd_addr_q[i][j] != exp_addr_q[i][j]) begin
          bad = j;
          break;
        end
      end
      checks++;
      if (bad != -1 || rd_addr_q[i].size() != NP) begin
        errors++;
        $display("FAIL bitrev_addr_seq inst%0d: read %0d of %0d has address %0d, expected %0d",
                 i, bad, rd_addr_q[i].size(),
                 (bad >= 0 && bad < rd_addr_q[i].size()) ? int'(rd_addr_q[i][bad]) : -1,
                 (bad >= 0) ? int'(exp_addr_q[i][bad]) : -1);
      end
    end
    idx_err = 0;
    last_cnt = 0;
    last_pos = -1;
    for (int j = 0; j < got_q[1].size() && j < rd_addr_q[1].size(); j++) begin
      pay = got_q[1][j];
      if (pay[AW:1] != rd_addr_q[1][j]) idx_err++;
      if (pay[0]) begin last_cnt++; last_pos = j; end
    end
    checks++;
    if (idx_err != 0 || got_q[1].size() != NP) begin
      errors++;
      $display("FAIL bitrev_index inst1: %0d m_index values differ from their read address over %0d beats, expected 0 over %0d",
               idx_err, got_q[1].size(), NP);
    end
    checks++;
    if (last_cnt != 1 || last_pos != NP - 1) begin
      errors++;
      $display("FAIL bitrev_last inst1: m_last seen %0d times, last at beat %0d, expected once at beat %0d",
               last_cnt, last_pos, NP - 1);
    end
  endtask

  task automatic test_random_ready();
    int n;
    bit ok;
    int bad;
    fill_mem(1'b1);
    build_exp();
    rmode = 1;
    mon_clear();
    pulse_done(n);
    wait_frame(2000, ok);
    rmode = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL random_ready_timeout: no frame_done within 2000 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = first_bad(i);
      checks++;
      if (bad != -1) begin
        errors++;
        $display("FAIL random_ready_frame inst%0d: beat %0d got %h (of %0d beats), expected %h (of %0d)",
                 i, bad, got_at(i, bad), got_q[i].size(), exp_at(i, bad), NP);
      end
      checks++;
      if (stall_viol[i] != 0 || max_out[i] > 2) begin
        errors++;
        $display("FAIL random_ready_stall inst%0d: %0d unstable stall cycles, max outstanding %0d, expected 0 and at most 2",
                 i, stall_viol[i], max_out[i]);
      end
    end
  endtask

  task automatic test_stall_start();
    int n;
    bit ok;
    int bad;
    fill_mem(1'b1);
    build_exp();
    rmode = 2;
    mon_clear();
    pulse_done(n);
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_addr_q[i].size() != 2 || got_q[i].size() != 0 || rd_en[i] !== 1'b0) begin
        errors++;
        $display("FAIL stall_start_reads inst%0d: %0d reads, %0d beats, rd_en=%b after 20 stalled cycles, expected 2, 0, 0",
                 i, rd_addr_q[i].size(), got_q[i].size(), rd_en[i]);
      end
    end
    rmode = 0;
    wait_frame(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_start_timeout: no frame_done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = first_bad(i);
      checks++;
      if (bad != -1 || stall_viol[i] != 0) begin
        errors++;
        $display("FAIL stall_start_frame inst%0d: first bad beat %0d got %h, expected %h; %0d unstable stall cycles",
                 i, bad, got_at(i, bad), exp_at(i, bad), stall_viol[i]);
      end
    end
  endtask

  task automatic test_done_dropped();
    int n, n2;
    bit ok;
    int bad;
    fill_mem(1'b1);
    build_exp();
    rmode = 0;
    mon_clear();
    pulse_done(n);
    wait_beats(10, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dropped_reach_beat10: fewer than 10 beats within 100 cycles"); end
    pulse_done(n2);
    wait_frame(400, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL dropped_timeout: no frame_done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = first_bad(i);
      checks++;
      if (bad != -1) begin
        errors++;
        $display("FAIL dropped_frame inst%0d: beat %0d got %h (of %0d beats), expected %h (of %0d)",
                 i, bad, got_at(i, bad), got_q[i].size(), exp_at(i, bad), NP);
      end
      checks++;
      if (done_dropped[i] !== 1'b1 || rd_addr_q[i].size() != NP || fd_st_q[i].size() != 1 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL dropped_flag inst%0d: done_dropped=%b reads=%0d frame_done pulses=%0d busy=%b, expected 1, %0d, 1, 0",
                 i, done_dropped[i], rd_addr_q[i].size(), fd_st_q[i].size(), busy[i], NP);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit ok;
    int bad;
    fill_mem(1'b1);
    rmode = 0;
    mon_clear();
    pulse_done(n);
    wait_beats(30, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_reach_beat30: fewer than 30 beats within 100 cycles"); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rd_en[i], addr_out[i], m_valid[i], m_real[i], m_imag[i], m_index[i], m_last[i],
           busy[i], frame_done[i], done_dropped[i]} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs inst%0d: rd_en=%b addr=%0d valid=%b index=%0d busy=%b dropped=%b, expected all zero",
                 i, rd_en[i], addr_out[i], m_valid[i], m_index[i], busy[i], done_dropped[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mon_clear();
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_addr_q[i].size() != 0 || valid_cycles[i] != 0) begin
        errors++;
        $display("FAIL midreset_quiet inst%0d: reads=%0d valid cycles=%0d after release, expected 0 and 0",
                 i, rd_addr_q[i].size(), valid_cycles[i]);
      end
    end
    fill_mem(1'b1);
    build_exp();
    mon_clear();
    pulse_done(n);
    wait_frame(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_timeout: no frame_done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      bad = first_bad(i);
      checks++;
      if (bad != -1 || done_dropped[i] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_frame inst%0d: beat %0d got %h (of %0d beats), expected %h; done_dropped=%b expected 0",
                 i, bad, got_at(i, bad), got_q[i].size(), exp_at(i, bad), done_dropped[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_rate();
    test_bit_reverse();
    test_random_ready();
    test_stall_start();
    test_done_dropped();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
